serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller. It time-shares one instance of the team's 1-bit full_adder cell across all WIDTH bit positions, one bit per clock, LSB first. It sits in the ALU as the low-area add/sub path. It takes operands through a start pulse and returns result, carry and signed overflow with a one-cycle done pulse.

---
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared full_adder cell walks all WIDTH
// bit positions LSB first, one bit per clock, then reports result/carry/overflow.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);
  localparam int CW = $clog2(WIDTH);

  // Handshake: start is sampled only while idle (busy=0, done=0); done is a
  // one-cycle pulse and result/cout/overflow stay valid until the next accept.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and preload the carry.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB.
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: driver tasks push expected results into a
// queue, a negedge monitor pops and compares on every done pulse.

module tb_serial_add_ctrl;
  localparam int W  = 32;
  localparam int EW = W + 2;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic [1:0]   dbg_state;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int checks      = 0;
  int done_seen   = 0;
  int run_len     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (!n_rst) begin
      run_len = 0;
    end else begin
      if (busy) run_len++;
      else if (run_len != 0) begin
        check("busy_len", run_len, W);
        run_len = 0;
      end
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_done: done=1 with empty expected queue, result=0x%0h (cycle %0d)",
                   result, cyc);
        end else begin
          e = exp_q.pop_front();
          check("result",   result,   e[W-1:0]);
          check("cout",     cout,     e[W]);
          check("overflow", overflow, e[W+1]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input bit expect_done);
    wait_idle();
    a     = ai;
    b     = bi;
    sub   = si;
    start = 1'b1;
    if (expect_done) begin
      exp_q.push_back({eo, ec, er});
      vectors++;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_level(input logic want_busy, input logic want, input string name);
    int n = 0;
    @(negedge clk);
    while (((want_busy ? busy : done) !== want) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check(name, 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     busy,      0);
    check({tag, "_done"},     done,      0);
    check({tag, "_result"},   result,    0);
    check({tag, "_cout"},     cout,      0);
    check({tag, "_overflow"}, overflow,  0);
    check({tag, "_state"},    dbg_state, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int d0;
    int t1;
    int t2;
    n_rst = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // directed arithmetic vectors
    issue(32'd5,        32'd3,        1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1);
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    issue(32'd3,        32'd5,        1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    issue(32'd5,        32'd3,        1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    issue(32'h80000000, 32'h00000001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    issue(32'h12345678, 32'h12345678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // start pulses during RUN and DONE must be ignored
    wait_idle();
    d0 = done_seen;
    issue(32'd5, 32'd3, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    a = 32'd1; b = 32'd1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_level(1'b0, 1'b1, "wait_done_timeout");
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_start_result", result, 32'h0000_0008);
    check("ignored_start_busy",   busy,   0);
    check("single_done_pulse",    done_seen - d0, 1);

    // held start: accepts spaced WIDTH+2 cycles apart
    wait_idle();
    a = 32'd7; b = 32'd9; sub = 1'b0; start = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'd16});
    exp_q.push_back({1'b0, 1'b0, 32'd16});
    vectors += 2;
    wait_level(1'b1, 1'b1, "held_rise1_timeout");
    t1 = cyc;
    wait_level(1'b1, 1'b0, "held_fall_timeout");
    wait_level(1'b1, 1'b1, "held_rise2_timeout");
    t2 = cyc;
    start = 1'b0;
    check("accept_spacing", t2 - t1, W + 2);

    // reset mid-operation, asserted between clock edges
    issue(32'd5, 32'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    issue(32'd5, 32'd3, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b1);

    // drain
    begin
      int n = 0;
      while ((exp_q.size() != 0 || busy || done) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) check("drain_timeout", exp_q.size(), 0);
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
